qei_home_ctrl: RTL and testbench
================================

Name: qei_home_ctrl

Overview:
- Controller that sequences the quadrature-decoder counter core: gates it, homes it to zero on the encoder index pulse, and faults if no index arrives within a step budget.
- Also snapshots the 16-bit position and streams it out as two bytes over a valid/ready handshake.
- Sits between the top-level pin wrapper and the QEI counter; the counter itself is unchanged apart from its clear/enable inputs.

Parameters:
- MAX_SEEK_STEPS, 1024: decoded steps allowed in SEEK before FAULT; legal range 1..65535.
- REHOME_ON_INDEX, 0: if 1, every index rising edge in HOMED re-clears the counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_home  in  1  one-cycle command: begin homing
- abort  in  1  one-cycle command: stop, go to IDLE
- index_i  in  1  raw asynchronous encoder index pin
- qei_step  in  1  one-cycle pulse from counter core on each count change
- qei_count  in  16  current counter value
- qei_en  out  1  counter enable
- qei_clr  out  1  one-cycle synchronous clear to counter core
- homed  out  1  high in HOMED
- fault  out  1  high in FAULT
- state_o  out  2  IDLE=0, SEEK=1, HOMED=2, FAULT=3
- snap_req  in  1  one-cycle request to capture qei_count
- rd_valid  out  1  readout byte valid
- rd_data  out  8  readout byte
- rd_ready  in  1  consumer accepts byte
- snap_ovr  out  1  sticky: snap_req arrived while readout busy

Behaviour:
Reset:
- Every output is 0; FSM is IDLE; readout is R_IDLE; seek counter is 0; shadow register is 0.
- Reset mid-operation aborts any in-flight readout with no partial byte.

Index synchronisation:
- index_i passes through a 2-FF synchroniser, then a registered rising-edge detect (idx_rise).
- qei_clr is registered: it is high exactly one cycle, on the 4th rising clk edge after index_i rises (setup met).
- Index high for many cycles yields exactly one idx_rise.

Homing FSM (registered outputs; state changes on the edge after the command):
- IDLE: qei_en=0.
  - start_home -> SEEK; seek counter cleared.
- SEEK: qei_en=1.
  - Each qei_step increments the 16-bit seek counter.
  - idx_rise -> pulse qei_clr, go to HOMED.
  - Else if the seek counter reaches MAX_SEEK_STEPS -> FAULT.
  - idx_rise and limit reached in the same cycle: index wins (HOMED).
  - start_home in SEEK restarts the seek counter.
- HOMED: qei_en=1, homed=1.
  - idx_rise with REHOME_ON_INDEX=1 -> qei_clr pulse, stay HOMED.
  - start_home -> SEEK (re-home).
- FAULT: qei_en=0, fault=1.
  - start_home -> SEEK (fault clears).
- abort in any state -> IDLE next cycle; abort has priority over start_home and idx_rise in the same cycle.
- qei_clr never asserts outside SEEK→HOMED or HOMED re-home.

Readout FSM (independent of homing):
- R_IDLE + snap_req: shadow <= qei_count; next cycle rd_valid=1, rd_data=shadow[7:0], state R_LO; snap_ovr cleared.
- R_LO: on rd_valid&rd_ready -> rd_data=shadow[15:8], state R_HI, rd_valid stays 1.
- R_HI: on rd_valid&rd_ready -> rd_valid=0, R_IDLE.
- rd_data and rd_valid are held stable while rd_valid=1 and rd_ready=0.
- snap_req in R_LO/R_HI: ignored, snap_ovr set (sticky); shadow is not changed.
- snap_req in the same cycle as the final handshake: counts as busy (ignored, snap_ovr set).
- Minimum gap between snapshots is 3 cycles with rd_ready held high.
- Capture is coherent: both bytes come from the same cycle's qei_count, even if qei_clr fires mid-readout.

Test Plan:
- Reset, start_home, 10 qei_step pulses, index_i high for 20 cycles -> state_o 0→1→2; exactly one qei_clr, 4 edges after index rise; homed=1; qei_en=1 from the cycle after start_home.
- MAX_SEEK_STEPS=8, start_home, 8 qei_step pulses with no index -> FAULT after the 8th step; qei_en=0; fault=1. Then start_home -> SEEK, fault=0.
- HOMED, abort together with start_home -> IDLE; qei_en=0; no qei_clr.
- REHOME_ON_INDEX=1 in HOMED, two index pulses -> two qei_clr pulses. With REHOME_ON_INDEX=0 -> none.
- qei_count=16'hA55A, snap_req, rd_ready low 5 cycles then high -> rd_data 8'h5A held stable, then 8'hA5, then rd_valid=0. A snap_req during R_LO sets snap_ovr=1 and bytes stay 5A/A5.
- Readout in flight with qei_count changing every cycle -> both bytes match the value captured at snap_req. Assert rst_n low mid-R_HI -> rd_valid=0 immediately.

Source files
------------

// File: rtl/qei_home_ctrl.sv
// Homing sequencer for the QEI counter core plus a two-byte position snapshot readout.
// Latency: qei_clr 4 edges after index_i rises; state change 1 edge after a command; first byte 1 edge after snap_req.
// Backpressure: rd_valid/rd_data hold while rd_ready is low; snap_req while busy is dropped and flagged in snap_ovr.
`timescale 1ns/1ps
module qei_home_ctrl #(
  parameter int unsigned MAX_SEEK_STEPS  = 1024,
  parameter bit          REHOME_ON_INDEX = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_home,
  input  logic        abort,
  input  logic        index_i,
  input  logic        qei_step,
  input  logic [15:0] qei_count,
  output logic        qei_en,
  output logic        qei_clr,
  output logic        homed,
  output logic        fault,
  output logic [1:0]  state_o,
  input  logic        snap_req,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_ready,
  output logic        snap_ovr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEEK  = 2'd1;
  localparam logic [1:0] S_HOMED = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_LO   = 2'd1;
  localparam logic [1:0] R_HI   = 2'd2;

  localparam logic [15:0] SEEK_LIMIT = 16'(MAX_SEEK_STEPS);

  logic        r_idx_s1;
  logic        r_idx_s2;
  logic        r_idx_prev;
  logic        r_idx_rise;

  logic [1:0]  r_state;
  logic [15:0] r_seek_cnt;
  logic        r_qei_en;
  logic        r_qei_clr;
  logic        r_homed;
  logic        r_fault;

  logic [1:0]  w_state_nxt;
  logic [15:0] w_seek_nxt;
  logic        w_clr_nxt;

  logic [1:0]  r_rd_state;
  logic        r_rd_valid;
  logic [15:0] r_shadow;
  logic        r_snap_ovr;

  logic        w_rd_busy;
  logic        w_rd_hs;

  // Two-flop synchroniser on the raw index pin followed by a registered rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx_s1   <= 1'b0;
      r_idx_s2   <= 1'b0;
      r_idx_prev <= 1'b0;
      r_idx_rise <= 1'b0;
    end else begin
      r_idx_s1   <= index_i;
      r_idx_s2   <= r_idx_s1;
      r_idx_prev <= r_idx_s2;
      r_idx_rise <= r_idx_s2 & ~r_idx_prev;
    end
  end

  // Homing next-state: abort beats everything, then start_home, then index, then the seek limit.
  always_comb begin
    w_state_nxt = r_state;
    w_seek_nxt  = r_seek_cnt;
    w_clr_nxt   = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_home) begin
            w_state_nxt = S_SEEK;
            w_seek_nxt  = 16'd0;
          end
        end
        S_SEEK: begin
          if (start_home) begin
            w_seek_nxt = 16'd0;
          end else if (r_idx_rise) begin
            w_state_nxt = S_HOMED;
            w_clr_nxt   = 1'b1;
          end else if (r_seek_cnt >= SEEK_LIMIT) begin
            w_state_nxt = S_FAULT;
          end else if (qei_step) begin
            w_seek_nxt = r_seek_cnt + 16'd1;
          end
        end
        S_HOMED: begin
          if (start_home) begin
            w_state_nxt = S_SEEK;
            w_seek_nxt  = 16'd0;
          end else if (r_idx_rise && REHOME_ON_INDEX) begin
            w_clr_nxt = 1'b1;
          end
        end
        default: begin
          if (start_home) begin
            w_state_nxt = S_SEEK;
            w_seek_nxt  = 16'd0;
          end
        end
      endcase
    end
  end

  // Homing state and registered decode of its outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_seek_cnt <= 16'd0;
      r_qei_en   <= 1'b0;
      r_qei_clr  <= 1'b0;
      r_homed    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_seek_cnt <= w_seek_nxt;
      r_qei_en   <= (w_state_nxt == S_SEEK) || (w_state_nxt == S_HOMED);
      r_qei_clr  <= w_clr_nxt;
      r_homed    <= (w_state_nxt == S_HOMED);
      r_fault    <= (w_state_nxt == S_FAULT);
    end
  end

  assign qei_en  = r_qei_en;
  assign qei_clr = r_qei_clr;
  assign homed   = r_homed;
  assign fault   = r_fault;
  assign state_o = r_state;

  assign w_rd_busy = (r_rd_state != R_IDLE);
  assign w_rd_hs   = r_rd_valid & rd_ready;

  // Readout sequencer: capture the whole count at once so both bytes are coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= R_IDLE;
      r_rd_valid <= 1'b0;
      r_shadow   <= 16'd0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (snap_req) begin
            r_shadow   <= qei_count;
            r_rd_valid <= 1'b1;
            r_rd_state <= R_LO;
          end
        end
        R_LO: begin
          if (w_rd_hs) begin
            r_rd_state <= R_HI;
          end
        end
        R_HI: begin
          if (w_rd_hs) begin
            r_rd_valid <= 1'b0;
            r_rd_state <= R_IDLE;
          end
        end
        default: begin
          r_rd_valid <= 1'b0;
          r_rd_state <= R_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun: set by a snapshot request that lands while a readout is in flight,
  // cleared when a new snapshot is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_ovr <= 1'b0;
    end else if (snap_req) begin
      r_snap_ovr <= w_rd_busy;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = (r_rd_state == R_HI) ? r_shadow[15:8] : r_shadow[7:0];
  assign snap_ovr = r_snap_ovr;

endmodule

// File: tb/tb_qei_home_ctrl.sv
`timescale 1ns/1ps
module tb_qei_home_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_home, abort, index_i, qei_step, snap_req, rd_ready;
  logic [15:0] qei_count;

  logic        en_o[2], clr_o[2], homed_o[2], fault_o[2], rdv_o[2], ovr_o[2];
  logic [1:0]  st_o[2];
  logic [7:0]  rdd_o[2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut0: default limit, no re-home; dut1: short limit, re-home on every index.
  qei_home_ctrl #(.MAX_SEEK_STEPS(1024), .REHOME_ON_INDEX(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_home(start_home), .abort(abort),
    .index_i(index_i), .qei_step(qei_step), .qei_count(qei_count),
    .qei_en(en_o[0]), .qei_clr(clr_o[0]), .homed(homed_o[0]), .fault(fault_o[0]),
    .state_o(st_o[0]), .snap_req(snap_req), .rd_valid(rdv_o[0]), .rd_data(rdd_o[0]),
    .rd_ready(rd_ready), .snap_ovr(ovr_o[0])
  );

  qei_home_ctrl #(.MAX_SEEK_STEPS(8), .REHOME_ON_INDEX(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_home(start_home), .abort(abort),
    .index_i(index_i), .qei_step(qei_step), .qei_count(qei_count),
    .qei_en(en_o[1]), .qei_clr(clr_o[1]), .homed(homed_o[1]), .fault(fault_o[1]),
    .state_o(st_o[1]), .snap_req(snap_req), .rd_valid(rdv_o[1]), .rd_data(rdd_o[1]),
    .rd_ready(rd_ready), .snap_ovr(ovr_o[1])
  );

  // Reference model state
  int         max_steps[2] = '{1024, 8};
  bit         rehome[2]    = '{1'b0, 1'b1};
  int         m_state[2];
  int         m_steps[2];
  logic       m_clr[2];
  logic       h1, h2, h3, h4;     // index_i as sampled on the previous four edges
  logic [7:0] m_bytes[$];         // bytes still to be delivered, oldest first
  logic       m_ovr;
  int         clr_cnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0;
      m_steps[i] = 0;
      m_clr[i]   = 1'b0;
    end
    {h1, h2, h3, h4} = 4'b0000;
    m_bytes.delete();
    m_ovr = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic rise;
    logic busy;
    // An index rise sampled at edge k is acted upon at edge k+3.
    rise = h3 & ~h4;
    for (int i = 0; i < 2; i++) begin
      m_clr[i] = 1'b0;
      if (abort) begin
        m_state[i] = 0;
      end else if (start_home) begin
        m_state[i] = 1;
        m_steps[i] = 0;
      end else if (m_state[i] == 1) begin
        if (rise) begin
          m_state[i] = 2;
          m_clr[i]   = 1'b1;
        end else if (m_steps[i] >= max_steps[i]) begin
          m_state[i] = 3;
        end else begin
          m_steps[i] += int'(qei_step);
        end
      end else if (m_state[i] == 2 && rise && rehome[i]) begin
        m_clr[i] = 1'b1;
      end
    end
    busy = (m_bytes.size() != 0);
    if (busy && rd_ready) void'(m_bytes.pop_front());
    if (snap_req) begin
      if (busy) m_ovr = 1'b1;
      else begin
        m_bytes.push_back(qei_count[7:0]);
        m_bytes.push_back(qei_count[15:8]);
        m_ovr = 1'b0;
      end
    end
    h4 = h3; h3 = h2; h2 = h1; h1 = index_i;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_state", i), 32'(st_o[i]), 32'(m_state[i]));
      chk($sformatf("d%0d_en", i), 32'(en_o[i]), 32'(m_state[i] == 1 || m_state[i] == 2));
      chk($sformatf("d%0d_homed", i), 32'(homed_o[i]), 32'(m_state[i] == 2));
      chk($sformatf("d%0d_fault", i), 32'(fault_o[i]), 32'(m_state[i] == 3));
      chk($sformatf("d%0d_clr", i), 32'(clr_o[i]), 32'(m_clr[i]));
      chk($sformatf("d%0d_rd_valid", i), 32'(rdv_o[i]), 32'(m_bytes.size() != 0));
      chk($sformatf("d%0d_snap_ovr", i), 32'(ovr_o[i]), 32'(m_ovr));
      if (m_bytes.size() != 0)
        chk($sformatf("d%0d_rd_data", i), 32'(rdd_o[i]), 32'(m_bytes[0]));
    end
  endtask

  // One clock: model, edge, sample 1ns later, then drop the one-cycle commands.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    for (int i = 0; i < 2; i++) if (clr_o[i] === 1'b1) clr_cnt[i]++;
    start_home = 1'b0;
    abort      = 1'b0;
    qei_step   = 1'b0;
    snap_req   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_d%0d_state", i), 32'(st_o[i]), 32'd0);
      chk($sformatf("rst_d%0d_outs", i),
          32'({en_o[i], clr_o[i], homed_o[i], fault_o[i], rdv_o[i], ovr_o[i]}), 32'd0);
      chk($sformatf("rst_d%0d_rd_data", i), 32'(rdd_o[i]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idx_pulse(input int hi, input int lo);
    index_i = 1'b1;
    repeat (hi) tick();
    index_i = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    int c0, c1;
    logic [15:0] cap;
    rst_n = 1'b0; start_home = 1'b0; abort = 1'b0; index_i = 1'b0; qei_step = 1'b0;
    snap_req = 1'b0; rd_ready = 1'b0; qei_count = 16'h0000;
    clr_cnt[0] = 0; clr_cnt[1] = 0;
    #2;
    do_reset();

    // Homing on dut0; dut1 runs out of its 8-step budget on the same stimulus.
    start_home = 1'b1;
    tick();
    chk("t1_en_after_start", 32'(en_o[0]), 32'd1);
    chk("t1_state_seek", 32'(st_o[0]), 32'd1);
    for (int n = 0; n < 10; n++) begin
      qei_step = 1'b1;
      tick();
      tick();
    end
    chk("t1_d1_fault", 32'(fault_o[1]), 32'd1);
    chk("t1_d1_en_off", 32'(en_o[1]), 32'd0);
    chk("t1_d0_still_seek", 32'(st_o[0]), 32'd1);
    c0 = clr_cnt[0];
    index_i = 1'b1;
    repeat (3) tick();
    chk("t1_no_clr_early", 32'(clr_o[0]), 32'd0);
    tick();
    chk("t1_clr_4th_edge", 32'(clr_o[0]), 32'd1);
    repeat (16) tick();
    index_i = 1'b0;
    repeat (6) tick();
    chk("t1_one_clr", 32'(clr_cnt[0] - c0), 32'd1);
    chk("t1_homed", 32'(homed_o[0]), 32'd1);
    chk("t1_state_homed", 32'(st_o[0]), 32'd2);

    // Fault recovery via start_home.
    start_home = 1'b1;
    tick();
    chk("t2_d1_seek", 32'(st_o[1]), 32'd1);
    chk("t2_d1_fault_clear", 32'(fault_o[1]), 32'd0);

    // Home both, then abort together with start_home.
    idx_pulse(3, 8);
    chk("t3_d0_homed", 32'(st_o[0]), 32'd2);
    chk("t3_d1_homed", 32'(st_o[1]), 32'd2);
    abort = 1'b1;
    start_home = 1'b1;
    tick();
    chk("t3_d0_idle", 32'(st_o[0]), 32'd0);
    chk("t3_d1_idle", 32'(st_o[1]), 32'd0);
    chk("t3_en_off", 32'(en_o[0] | en_o[1]), 32'd0);
    chk("t3_no_clr", 32'(clr_o[0] | clr_o[1]), 32'd0);

    // Re-home on index: dut1 clears on each pulse, dut0 does not.
    start_home = 1'b1;
    tick();
    idx_pulse(5, 8);
    c0 = clr_cnt[0];
    c1 = clr_cnt[1];
    idx_pulse(5, 8);
    idx_pulse(5, 8);
    chk("t4_rehome0_none", 32'(clr_cnt[0] - c0), 32'd0);
    chk("t4_rehome1_two", 32'(clr_cnt[1] - c1), 32'd2);

    // Readout with backpressure and an overrun request during R_LO.
    qei_count = 16'hA55A;
    snap_req = 1'b1;
    rd_ready = 1'b0;
    tick();
    for (int n = 0; n < 5; n++) begin
      qei_count = 16'($urandom);
      if (n == 2) snap_req = 1'b1;
      tick();
      chk("t5_lo_held", 32'(rdd_o[0]), 32'h5A);
    end
    chk("t5_ovr_set", 32'(ovr_o[0]), 32'd1);
    rd_ready = 1'b1;
    tick();
    chk("t5_hi_byte", 32'(rdd_o[0]), 32'hA5);
    tick();
    chk("t5_done", 32'(rdv_o[0]), 32'd0);

    // Back-to-back snapshots at the minimum 3-cycle spacing.
    for (int n = 0; n < 4; n++) begin
      qei_count = 16'($urandom);
      snap_req = 1'b1;
      tick();
      tick();
      tick();
    end
    chk("t6_gap_no_ovr", 32'(ovr_o[1]), 32'd0);

    // Coherent capture with a moving count, then reset mid-R_HI.
    cap = 16'($urandom);
    qei_count = cap;
    snap_req = 1'b1;
    tick();
    qei_count = 16'($urandom);
    tick();
    rd_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      qei_count = 16'($urandom);
      tick();
    end
    chk("t7_hi_coherent", 32'(rdd_o[1]), 32'(cap[15:8]));
    do_reset();
    chk("t7_valid_dropped", 32'(rdv_o[0]), 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      qei_count  = 16'($urandom);
      qei_step   = ($urandom_range(0, 9) < 3);
      start_home = ($urandom_range(0, 59) == 0);
      abort      = ($urandom_range(0, 99) == 0);
      snap_req   = ($urandom_range(0, 4) == 0);
      rd_ready   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 11) == 0) index_i = ~index_i;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
